// File: rtl/main_control_pkg.sv
// Shared encodings for the multicycle main controller: states, opcodes,
// function codes and the datapath mux selects it drives.
`default_nettype none

package main_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_ALU_WB   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_JR       = 4'd11,
        ST_COPY     = 4'd12,
        ST_LI       = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ADDI  = 4'h1,
        OP_BEQ   = 4'h2,
        OP_BNE   = 4'h3,
        OP_J     = 4'h4,
        OP_LW    = 4'h5,
        OP_SW    = 4'h6,
        OP_RSVD  = 4'h7,
        OP_LI    = 4'h8,
        OP_ORI   = 4'h9,
        OP_ANDI  = 4'hA,
        OP_XORI  = 4'hB,
        OP_SLTI  = 4'hC,
        OP_SUBI  = 4'hD,
        OP_BEQZ  = 4'hE,
        OP_BNEZ  = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        FN_COPY = 4'h6,
        FN_JR   = 4'h7
    } func_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REGA   = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MDR    = 2'b01,
        WB_IMM    = 2'b10,
        WB_REGA   = 2'b11
    } wb_src_t;

    typedef enum logic [1:0] {
        BSEL_B    = 2'b00,
        BSEL_INC  = 2'b01,
        BSEL_SEXT = 2'b10,
        BSEL_ZEXT = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_FUNC = 2'b10
    } alu_phase_t;

    // Logical immediates take a zero-extended operand, arithmetic ones sign-extended.
    function automatic logic is_zext_op(input logic [3:0] opc);
        return (opc == OP_ORI) || (opc == OP_ANDI) || (opc == OP_XORI);
    endfunction

    function automatic logic branch_taken(input logic [3:0] opc, input logic z);
        return (((opc == OP_BEQ) || (opc == OP_BEQZ)) &&  z) ||
               (((opc == OP_BNE) || (opc == OP_BNEZ)) && !z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/main_control.sv
// Multicycle processor main controller: registered state with next-state
// and output decode derived from the current state and instruction fields.
`default_nettype none

module main_control
    import main_control_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int PC_INC = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] func,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic [1:0]      wb_src,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_phase,
    output logic            instr_done,
    output logic [3:0]      state
);

    // The decode tables assume 4-bit fields; PC_INC is consumed by the datapath.
    if (OP_W != 4 || PC_INC < 1) begin : g_param_check
        $error("main_control: OP_W must be 4 and PC_INC positive");
    end

    state_t cur_state;
    state_t nxt_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= ST_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    assign state = cur_state;

    always_comb begin
        nxt_state = ST_FETCH;
        case (cur_state)
            ST_FETCH:    nxt_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (func == FN_COPY)    nxt_state = ST_COPY;
                        else if (func == FN_JR) nxt_state = ST_JR;
                        else                    nxt_state = ST_EXEC_R;
                    end
                    OP_ADDI, OP_ORI, OP_ANDI, OP_XORI,
                    OP_SLTI, OP_SUBI:           nxt_state = ST_EXEC_I;
                    OP_LW, OP_SW:               nxt_state = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE,
                    OP_BEQZ, OP_BNEZ:           nxt_state = ST_BRANCH;
                    OP_J:                       nxt_state = ST_JUMP;
                    OP_LI:                      nxt_state = ST_LI;
                    default:                    nxt_state = ST_FETCH;
                endcase
            end
            ST_EXEC_R,
            ST_EXEC_I:   nxt_state = ST_ALU_WB;
            ST_MEM_ADDR: nxt_state = (op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   nxt_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   nxt_state = mem_ready ? ST_FETCH : ST_MEM_WR;
            default:     nxt_state = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_src     = WB_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = BSEL_B;
        alu_phase  = ALU_ADD;
        instr_done = 1'b0;
        case (cur_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = BSEL_INC;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_b  = BSEL_SEXT;
                instr_done = (op == OP_RSVD);
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_phase = ALU_FUNC;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = is_zext_op(op) ? BSEL_ZEXT : BSEL_SEXT;
                alu_phase = ALU_FUNC;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = BSEL_SEXT;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                wb_src     = WB_MDR;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_phase  = ALU_FUNC;
                pc_src     = PC_ALUOUT;
                pc_write   = branch_taken(op, zero);
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_JUMP;
                instr_done = 1'b1;
            end
            ST_JR: begin
                pc_write   = 1'b1;
                pc_src     = PC_REGA;
                instr_done = 1'b1;
            end
            ST_COPY: begin
                reg_write  = 1'b1;
                wb_src     = WB_REGA;
                instr_done = 1'b1;
            end
            ST_LI: begin
                reg_write  = 1'b1;
                wb_src     = WB_IMM;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_main_control.sv
// Directed self-checking bench for main_control.
`default_nettype none

module tb_main_control;
    import main_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] op = 4'h0;
    logic [3:0] func = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic       alu_src_a, instr_done;
    logic [1:0] pc_src, wb_src, alu_src_b, alu_phase;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;

    // Observations gathered over one instruction
    int         o_done, o_pcw, o_regw, o_memw, o_stall;
    logic [1:0] o_pcs, o_wb, o_bsel;

    main_control #(.OP_W(4), .PC_INC(2)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .wb_src(wb_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_phase(alu_phase),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    // Runs one instruction starting in FETCH; cycle 1 is the FETCH cycle.
    task automatic run_instr(input logic [3:0] o, input logic [3:0] f,
                             input logic z, input int stalls);
        int left;
        left = stalls;
        o_done = 0; o_pcw = 0; o_regw = 0; o_memw = 0; o_stall = 0;
        o_pcs = 2'b00; o_wb = 2'b00; o_bsel = 2'b00;
        op = o; func = f; zero = z;
        for (int c = 1; c <= 20; c++) begin
            mem_ready = 1'b1;
            if ((state == ST_MEM_RD || state == ST_MEM_WR) && left > 0) begin
                mem_ready = 1'b0;
                left--;
                o_stall++;
            end
            #1;
            if (state != ST_FETCH && pc_write) begin o_pcw++; o_pcs = pc_src; end
            if (reg_write) begin o_regw++; o_wb = wb_src; end
            if (mem_write) o_memw++;
            if (state == ST_EXEC_I) o_bsel = alu_src_b;
            if (instr_done) o_done = c;
            @(posedge clk); #1;
            if (o_done != 0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (state !== 4'd0) $display("FAIL reset_state got %0d expected 0", state); else passed++;
        total++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || alu_phase !== 2'b00 || i_or_d !== 1'b0)
            $display("FAIL reset_fetch_decode got rd=%b b=%b ph=%b iod=%b expected 1 01 00 0",
                     mem_read, alu_src_b, alu_phase, i_or_d); else passed++;
        total++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL reset_strobes got ir=%b pc=%b rw=%b mw=%b expected 0", ir_write, pc_write, reg_write, mem_write); else passed++;
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        total++; if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00)
            $display("FAIL release_fetch got st=%0d ir=%b pc=%b src=%b expected 0 1 1 00",
                     state, ir_write, pc_write, pc_src); else passed++;
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0; op = 4'h8;
        @(posedge clk); @(posedge clk); #1;
        total++; if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1)
            $display("FAIL fetch_stall got st=%0d ir=%b pc=%b rd=%b expected 0 0 0 1",
                     state, ir_write, pc_write, mem_read); else passed++;
    endtask

    task automatic test_lw_stall();
        run_instr(4'h5, 4'h0, 1'b0, 3);
        total++; if (o_done !== 8) $display("FAIL lw_done_cycle got %0d expected 8", o_done); else passed++;
        total++; if (o_regw !== 1 || o_wb !== 2'b01) $display("FAIL lw_writeback got n=%0d wb=%b expected 1 01", o_regw, o_wb); else passed++;
        total++; if (o_stall !== 3) $display("FAIL lw_stall got %0d expected 3", o_stall); else passed++;
        total++; if (state !== 4'd0) $display("FAIL lw_return got %0d expected 0", state); else passed++;
    endtask

    task automatic test_branch();
        run_instr(4'h2, 4'h0, 1'b1, 0);
        total++; if (o_done !== 3 || o_pcw !== 1 || o_pcs !== 2'b01)
            $display("FAIL beq_taken got done=%0d pcw=%0d src=%b expected 3 1 01", o_done, o_pcw, o_pcs); else passed++;
        run_instr(4'h3, 4'h0, 1'b1, 0);
        total++; if (o_done !== 3 || o_pcw !== 0)
            $display("FAIL bne_not_taken got done=%0d pcw=%0d expected 3 0", o_done, o_pcw); else passed++;
        run_instr(4'hE, 4'h0, 1'b0, 0);
        total++; if (o_pcw !== 0) $display("FAIL beqz_not_taken got pcw=%0d expected 0", o_pcw); else passed++;
        run_instr(4'hF, 4'h0, 1'b0, 0);
        total++; if (o_pcw !== 1 || o_pcs !== 2'b01) $display("FAIL bnez_taken got pcw=%0d src=%b expected 1 01", o_pcw, o_pcs); else passed++;
    endtask

    task automatic test_rtype();
        run_instr(4'h0, 4'h7, 1'b0, 0);
        total++; if (o_done !== 3 || o_pcw !== 1 || o_pcs !== 2'b11 || o_regw !== 0)
            $display("FAIL jr got done=%0d pcw=%0d src=%b rw=%0d expected 3 1 11 0", o_done, o_pcw, o_pcs, o_regw); else passed++;
        run_instr(4'h0, 4'h6, 1'b0, 0);
        total++; if (o_done !== 3 || o_regw !== 1 || o_wb !== 2'b11)
            $display("FAIL copy got done=%0d rw=%0d wb=%b expected 3 1 11", o_done, o_regw, o_wb); else passed++;
        run_instr(4'h0, 4'h0, 1'b0, 0);
        total++; if (o_done !== 4 || o_regw !== 1 || o_wb !== 2'b00 || o_pcw !== 0)
            $display("FAIL rtype got done=%0d rw=%0d wb=%b pcw=%0d expected 4 1 00 0", o_done, o_regw, o_wb, o_pcw); else passed++;
    endtask

    task automatic test_itype_unused();
        run_instr(4'h9, 4'h0, 1'b0, 0);
        total++; if (o_done !== 4 || o_bsel !== 2'b11 || o_regw !== 1)
            $display("FAIL ori got done=%0d bsel=%b rw=%0d expected 4 11 1", o_done, o_bsel, o_regw); else passed++;
        run_instr(4'h1, 4'h0, 1'b0, 0);
        total++; if (o_bsel !== 2'b10) $display("FAIL addi_bsel got %b expected 10", o_bsel); else passed++;
        run_instr(4'h7, 4'h0, 1'b0, 0);
        total++; if (o_done !== 2 || o_pcw !== 0 || o_regw !== 0 || o_memw !== 0)
            $display("FAIL unused got done=%0d pcw=%0d rw=%0d mw=%0d expected 2 0 0 0", o_done, o_pcw, o_regw, o_memw); else passed++;
        total++; if (state !== 4'd0) $display("FAIL unused_return got %0d expected 0", state); else passed++;
    endtask

    task automatic test_back_to_back();
        run_instr(4'h4, 4'h0, 1'b0, 0);
        total++; if (o_done !== 3 || o_pcw !== 1 || o_pcs !== 2'b10)
            $display("FAIL jump got done=%0d pcw=%0d src=%b expected 3 1 10", o_done, o_pcw, o_pcs); else passed++;
        run_instr(4'h8, 4'h0, 1'b0, 0);
        total++; if (o_done !== 3 || o_regw !== 1 || o_wb !== 2'b10)
            $display("FAIL li got done=%0d rw=%0d wb=%b expected 3 1 10", o_done, o_regw, o_wb); else passed++;
        run_instr(4'h6, 4'h0, 1'b0, 0);
        total++; if (o_done !== 4 || o_memw !== 1 || o_regw !== 0)
            $display("FAIL sw got done=%0d mw=%0d rw=%0d expected 4 1 0", o_done, o_memw, o_regw); else passed++;
        run_instr(4'h6, 4'h0, 1'b0, 2);
        total++; if (o_done !== 6) $display("FAIL sw_stall got done=%0d expected 6", o_done); else passed++;
    endtask

    task automatic test_reset_mid();
        op = 4'h6; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; mem_ready = 1'b0; #1;
        total++; if (state !== 4'd7 || mem_write !== 1'b1)
            $display("FAIL reach_mem_wr got st=%0d mw=%b expected 7 1", state, mem_write); else passed++;
        reset = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0)
            $display("FAIL reset_mid got st=%0d mw=%b rw=%b expected 0 0 0", state, mem_write, reg_write); else passed++;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_branch();
        test_rtype();
        test_itype_unused();
        test_back_to_back();
        test_fetch_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 Parameters: OP_W, 4, opcode/func field width; PC_INC, 2, PC increment constant selected by alu_src_b=01.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-004 op  in  OP_W  instruction opcode, instr[15:12], valid from DECODE onward.
REQ-005 func  in  OP_W  R-type function field, valid from DECODE onward.
REQ-006 zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  in  1  memory handshake; the current access completes in a cycle where it is 1.
REQ-008 Outputs (all 1 bit unless noted), Moore, decoded from state only: pc_write; pc_src[1:0] (00 ALU, 01 ALUOut, 10 jump target, 11 reg A); ir_write; i_or_d (0 PC, 1 ALUOut); mem_read; mem_write; reg_write; wb_src[1:0] (00 ALUOut, 01 MDR, 10 imm, 11 reg A); alu_src_a (0 PC, 1 A); alu_src_b[1:0] (00 B, 01 PC_INC, 10 sign-ext imm, 11 zero-ext imm); alu_phase[1:0] (00 force add, 01 force sub, 10 use op/func); instr_done; state[3:0].

Function
REQ-009 FSM states SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, JR, COPY, LI.
REQ-010 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_phase=00; while mem_ready=0 stay, no writes; when mem_ready=1 assert ir_write and pc_write (pc_src=00), go DECODE.
REQ-011 DECODE: alu_src_a=0, alu_src_b=10, alu_phase=00 (branch target into ALUOut); next state by op.
REQ-012 op=0: func 0110 -> COPY, 0111 -> JR, any other func -> EXEC_R.
REQ-013 op 1,9,A,B,C,D -> EXEC_I; 1,C,D use alu_src_b=10, 9,A,B use 11; alu_src_a=1, alu_phase=10.
REQ-014 op 5 (lw), 6 (sw) -> MEM_ADDR (alu_src_a=1, alu_src_b=10, alu_phase=00), then MEM_RD or MEM_WR.
REQ-015 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB (reg_write=1, wb_src=01).
REQ-016 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-017 EXEC_R: alu_src_a=1, alu_src_b=00, alu_phase=10, then ALU_WB (reg_write=1, wb_src=00).
REQ-018 op 2,3,E,F -> BRANCH: alu_src_a=1, alu_src_b=00, alu_phase=10; pc_src=01; pc_write=1 iff (op 2 or E and zero=1) or (op 3 or F and zero=0).
REQ-019 op 4 -> JUMP (pc_write=1, pc_src=10); JR: pc_write=1, pc_src=11; COPY: reg_write=1, wb_src=11; op 8 -> LI: reg_write=1, wb_src=10.
REQ-020 op 7 (unused) SHALL return DECODE -> FETCH with no write strobes.
REQ-021 Terminal states (MEM_WB, MEM_WR completing, ALU_WB, BRANCH, JUMP, JR, COPY, LI, DECODE for op 7) SHALL assert instr_done for exactly that cycle and go FETCH.
REQ-022 Latency with mem_ready=1: R/I-type 4, lw 5, sw 4, branch/jump/jr/copy/li 3 cycles.
REQ-023 Outputs not listed for a state SHALL be 0; pc_write, ir_write, reg_write, mem_read, mem_write never both strobes from a stalled access.
REQ-024 Unencoded state values SHALL go to FETCH next cycle with all strobes 0.

Reset
REQ-025 reset=0 at rising clk SHALL force FETCH and all outputs to 0 except FETCH decode values, next cycle; mid-instruction reset abandons it with no write strobe asserted afterwards.
REQ-026 Reset SHALL take precedence over mem_ready and all transitions.

Structure
REQ-027 Shared package holds state encodings, opcode/func constants, and pc_src, wb_src, alu_src_b, alu_phase encodings.
REQ-028 Single module: registered next-state block plus combinational output decode; no sub-module.

Verification
REQ-029 reset=0 two cycles, release, mem_ready=1 -> state FETCH, ir_write=1, pc_write=1 in first cycle.
REQ-030 op=5, mem_ready low 3 cycles in MEM_RD -> stall 3 cycles, reg_write=1 wb_src=01 once, instr_done after 8 cycles total.
REQ-031 op=2 zero=1 -> pc_write=1 pc_src=01; op=3 zero=1 -> pc_write=0; both instr_done at cycle 3.
REQ-032 op=0 func=0111 -> JR pc_src=11; func=0110 -> COPY wb_src=11; func=0000 -> 4-cycle R path.
REQ-033 op=9 -> alu_src_b=11 in EXEC_I; op=7 -> no strobes, back to FETCH at cycle 3.
REQ-034 reset=0 during MEM_WR -> mem_write=0 next cycle, state FETCH.
